// File: rtl/perf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | perf_pkg: CSR addresses, inhibit bit indices and address decode   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package perf_pkg;

   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

   // Counter CSR windows; unimplemented addresses inside them are illegal.
   localparam logic [11:0] CSR_MCNT_FIRST = 12'hB00;
   localparam logic [11:0] CSR_MCNT_LAST  = 12'hB9F;
   localparam logic [11:0] CSR_UCNT_FIRST = 12'hC00;
   localparam logic [11:0] CSR_UCNT_LAST  = 12'hC9F;

   localparam int INH_CY = 0;
   localparam int INH_IR = 2;

   typedef enum logic [2:0] {
      SEL_NONE    = 3'd0,
      SEL_CYC_LO  = 3'd1,
      SEL_CYC_HI  = 3'd2,
      SEL_INS_LO  = 3'd3,
      SEL_INS_HI  = 3'd4,
      SEL_INHIBIT = 3'd5
   } csr_sel_e;

   typedef struct packed {
      logic     hit;
      logic     ro;
      logic     in_range;
      csr_sel_e sel;
   } csr_dec_t;

   function automatic csr_dec_t csr_decode(input logic [11:0] addr);
      csr_dec_t d;
      d.hit      = 1'b0;
      d.ro       = 1'b0;
      d.sel      = SEL_NONE;
      d.in_range = ((addr >= CSR_MCNT_FIRST) && (addr <= CSR_MCNT_LAST)) ||
                   ((addr >= CSR_UCNT_FIRST) && (addr <= CSR_UCNT_LAST));
      case (addr)
         CSR_MCYCLE:        begin d.hit = 1'b1; d.sel = SEL_CYC_LO;  end
         CSR_MCYCLEH:       begin d.hit = 1'b1; d.sel = SEL_CYC_HI;  end
         CSR_MINSTRET:      begin d.hit = 1'b1; d.sel = SEL_INS_LO;  end
         CSR_MINSTRETH:     begin d.hit = 1'b1; d.sel = SEL_INS_HI;  end
         CSR_MCOUNTINHIBIT: begin d.hit = 1'b1; d.sel = SEL_INHIBIT; end
         CSR_CYCLE:         begin d.hit = 1'b1; d.ro = 1'b1; d.sel = SEL_CYC_LO; end
         CSR_CYCLEH:        begin d.hit = 1'b1; d.ro = 1'b1; d.sel = SEL_CYC_HI; end
         CSR_INSTRET:       begin d.hit = 1'b1; d.ro = 1'b1; d.sel = SEL_INS_LO; end
         CSR_INSTRETH:      begin d.hit = 1'b1; d.ro = 1'b1; d.sel = SEL_INS_HI; end
         default:           d.sel = SEL_NONE;
      endcase
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/perf_counter64.sv
`default_nettype none
// +------------------------------------------------------------------+
// | perf_counter64: width-parameterised counter, half-word writable   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module perf_counter64 #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wdata,
   output logic [CNT_WIDTH-1:0] count
);

   localparam int                   HI_W    = CNT_WIDTH - 32;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   // A write to either half suppresses the increment for the whole counter,
   // including any carry that would have reached the written half.
   always_comb begin
      count_d = count_q;
      if (wr_lo || wr_hi) begin
         if (wr_lo) begin
            count_d[31:0] = wdata;
         end
         if (wr_hi) begin
            count_d[CNT_WIDTH-1:32] = wdata[HI_W-1:0];
         end
      end else if (inc) begin
         count_d = count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/perf_counter_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | perf_counter_unit: mcycle/minstret/mcountinhibit CSR block        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module perf_counter_unit
   import perf_pkg::*;
#(
   parameter int         CNT_WIDTH   = 64,
   parameter logic [2:0] INHIBIT_RST = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instret_i,
   input  logic [11:0] csr_addr_i,
   input  logic        csr_rd_en_i,
   input  logic        csr_wr_en_i,
   input  logic [31:0] csr_wdata_i,
   output logic [31:0] csr_rdata_o,
   output logic        csr_hit_o,
   output logic        csr_illegal_o,
   output logic [31:0] cycle_counter_o,
   output logic [31:0] instret_counter_o
);

   csr_dec_t             dec;
   logic                 access;
   logic                 wr_ok;
   logic                 cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi, inh_wr;
   logic                 cy_inh_q, cy_inh_d;
   logic                 ir_inh_q, ir_inh_d;
   logic [CNT_WIDTH-1:0] mcycle;
   logic [CNT_WIDTH-1:0] minstret;
   logic [63:0]          mcycle_ext;
   logic [63:0]          minstret_ext;
   logic [31:0]          inh_word;
   logic [31:0]          rdata;

   assign dec    = csr_decode(csr_addr_i);
   assign access = csr_rd_en_i | csr_wr_en_i;
   // Read-only shadows never reach state.
   assign wr_ok  = csr_wr_en_i & dec.hit & ~dec.ro;

   assign cyc_wr_lo = wr_ok && (dec.sel == SEL_CYC_LO);
   assign cyc_wr_hi = wr_ok && (dec.sel == SEL_CYC_HI);
   assign ins_wr_lo = wr_ok && (dec.sel == SEL_INS_LO);
   assign ins_wr_hi = wr_ok && (dec.sel == SEL_INS_HI);
   assign inh_wr    = wr_ok && (dec.sel == SEL_INHIBIT);

   always_comb begin
      cy_inh_d = cy_inh_q;
      ir_inh_d = ir_inh_q;
      if (inh_wr) begin
         cy_inh_d = csr_wdata_i[INH_CY];
         ir_inh_d = csr_wdata_i[INH_IR];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cy_inh_q <= INHIBIT_RST[INH_CY];
         ir_inh_q <= INHIBIT_RST[INH_IR];
      end else begin
         cy_inh_q <= cy_inh_d;
         ir_inh_q <= ir_inh_d;
      end
   end

   // Increments use the inhibit value held before this edge.
   perf_counter64 #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_mcycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (~cy_inh_q),
      .wr_lo (cyc_wr_lo),
      .wr_hi (cyc_wr_hi),
      .wdata (csr_wdata_i),
      .count (mcycle)
   );

   perf_counter64 #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_minstret (
      .clk   (clk),
      .rst   (rst),
      .inc   (instret_i & ~ir_inh_q),
      .wr_lo (ins_wr_lo),
      .wr_hi (ins_wr_hi),
      .wdata (csr_wdata_i),
      .count (minstret)
   );

   assign mcycle_ext   = 64'(mcycle);
   assign minstret_ext = 64'(minstret);

   always_comb begin
      inh_word         = '0;
      inh_word[INH_CY] = cy_inh_q;
      inh_word[INH_IR] = ir_inh_q;
   end

   always_comb begin
      rdata = '0;
      if (csr_rd_en_i) begin
         case (dec.sel)
            SEL_CYC_LO:  rdata = mcycle_ext[31:0];
            SEL_CYC_HI:  rdata = mcycle_ext[63:32];
            SEL_INS_LO:  rdata = minstret_ext[31:0];
            SEL_INS_HI:  rdata = minstret_ext[63:32];
            SEL_INHIBIT: rdata = inh_word;
            default:     rdata = '0;
         endcase
      end
   end

   assign csr_rdata_o       = rdata;
   assign csr_hit_o         = access & dec.hit;
   assign csr_illegal_o     = access & ((dec.in_range & ~dec.hit) | (csr_wr_en_i & dec.ro));
   assign cycle_counter_o   = mcycle_ext[31:0];
   assign instret_counter_o = minstret_ext[31:0];

endmodule
`default_nettype wire
